uart_byte_rx: RTL and testbench

UART_BYTE_RX -- requirements
Module: uart_byte_rx

---
 rtl/uart_byte_rx_pkg.sv | 19 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_byte_rx.sv | 136 +++++++++++++
 tb/tb_uart_byte_rx.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_byte_rx_pkg.sv
// Shared definitions for the UART byte receiver.
//   state_e       : receiver FSM state encoding
//   clks_per_bit  : clock cycles per serial bit, CLK_HZ / BAUD (integer division)
package uart_byte_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK_WAIT
    } state_e;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line.
//   clk : system clock
//   rst : asynchronous active-high reset; both flops reset to 1 (line idle level)
//   d   : asynchronous input
//   q   : synchronized output
module uart_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            q      <= 1'b1;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// UART 8N1 byte receiver with a single-entry ready/valid holding register.
//   clk             : system clock, rising edge
//   rst             : asynchronous active-high reset
//   rx              : asynchronous serial line, idles high, LSB first
//   from_uart_ready : consumer accepts the held byte when high with from_uart_valid
//   from_uart_data  : received byte, stable while from_uart_valid is high
//   from_uart_valid : a byte is held and not yet accepted
//   from_uart_error : one-cycle pulse on a framing error or an overrun
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       from_uart_ready,
    output logic [7:0] from_uart_data,
    output logic       from_uart_valid,
    output logic       from_uart_error
);

    localparam int unsigned CPB  = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CntW = $clog2(CPB);
    localparam logic [CntW-1:0] HalfM1 = CntW'(CPB / 2 - 1);
    localparam logic [CntW-1:0] FullM1 = CntW'(CPB - 1);

    logic            rx_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            done, frame_err, load, overrun;

    uart_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done      = 1'b0;
        frame_err = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit to reject glitches.
                if (cnt_q == HalfM1) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        bit_idx_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FullM1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FullM1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_d   = BREAK_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            BREAK_WAIT: begin
                // A held-low line stays here so it reports only one error.
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A completed byte loads when the holder is empty or is being drained this cycle.
    assign load    = done && (!from_uart_valid || from_uart_ready);
    assign overrun = done && !load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= 3'd0;
            shift_q         <= 8'h00;
            from_uart_data  <= 8'h00;
            from_uart_valid <= 1'b0;
            from_uart_error <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            from_uart_error <= frame_err | overrun;
            if (load) begin
                from_uart_data  <= shift_q;
                from_uart_valid <= 1'b1;
            end else if (from_uart_valid && from_uart_ready) begin
                from_uart_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx at 16 clocks per bit.
module tb_uart_byte_rx;
    import uart_byte_rx_pkg::*;

    localparam int unsigned CLK_HZ = 1_843_200;
    localparam int unsigned BAUD   = 115200;
    localparam int          CPB    = CLK_HZ / BAUD;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       error;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Monitor results
    logic [7:0] got[$];
    int         err_seen;
    int         valid_cycles;
    int         rise_cyc;
    logic       valid_prev;

    uart_byte_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rx              (rx),
        .from_uart_ready (ready),
        .from_uart_data  (data),
        .from_uart_valid (valid),
        .from_uart_error (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Inputs change 2 time units after a rising edge; outputs are observed on the falling
    // edge, where valid/ready/data are exactly what the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) got.push_back(data);
            if (error) err_seen++;
            if (valid) valid_cycles++;
            if (valid && !valid_prev) rise_cyc = cyc;
        end
        valid_prev = valid;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        got.delete();
        err_seen     = 0;
        valid_cycles = 0;
        rise_cyc     = -1;
    endtask

    // Full frame; rx is left at the stop level afterwards.
    task automatic send(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = stop_bit;
        step(CPB);
    endtask

    task automatic check_queue(input string name, input logic [7:0] exp_q[$]);
        n_cmp++;
        if (got.size() !== exp_q.size()) begin
            n_bad++;
            $display("FAIL %s_count: got %0d bytes, expected %0d", name, got.size(),
                     exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                n_cmp++;
                if (got[i] !== exp_q[i]) begin
                    n_bad++;
                    $display("FAIL %s_byte%0d: got %02h, expected %02h", name, i, got[i],
                             exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        step(3);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_valid: got %b, expected 0", valid);
        end
        n_cmp++;
        if (error !== 1'b0) begin
            n_bad++; $display("FAIL reset_error: got %b, expected 0", error);
        end
        n_cmp++;
        if (data !== 8'h00) begin
            n_bad++; $display("FAIL reset_data: got %02h, expected 00", data);
        end
        rst = 1'b0;
        step(5);
    endtask

    task automatic test_single();
        logic [7:0] exp_q[$];
        int         start_cyc;
        int         lat;
        clear_mon();
        ready     = 1'b1;
        start_cyc = cyc;
        send(8'h73, 1'b1);
        step(20);
        exp_q = '{8'h73};
        check_queue("single", exp_q);
        n_cmp++;
        if (err_seen !== 0) begin
            n_bad++; $display("FAIL single_error: got %0d pulses, expected 0", err_seen);
        end
        n_cmp++;
        if (valid_cycles !== 1) begin
            n_bad++; $display("FAIL single_valid_cycles: got %0d, expected 1", valid_cycles);
        end
        // Measured from the raw line edge: 153 +/- 1 plus up to 2 synchronizer cycles.
        lat = rise_cyc - start_cyc - 1;
        n_cmp++;
        if (lat < 152 || lat > 156) begin
            n_bad++; $display("FAIL single_latency: got %0d, expected 152..156", lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        clear_mon();
        ready = 1'b1;
        exp_q = '{8'h73, 8'h02, 8'h00, 8'h14, 8'hDF, 8'h75};
        foreach (exp_q[i]) send(exp_q[i], 1'b1);
        // Random bytes with random idle gaps between frames.
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            step($urandom_range(0, 2 * CPB));
            send(b, 1'b1);
        end
        step(20);
        check_queue("b2b", exp_q);
        n_cmp++;
        if (err_seen !== 0) begin
            n_bad++; $display("FAIL b2b_error: got %0d pulses, expected 0", err_seen);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_q[$];
        clear_mon();
        ready = 1'b0;
        send(8'hA5, 1'b1);
        send(8'h3C, 1'b1);
        step(20);
        n_cmp++;
        if (valid !== 1'b1) begin
            n_bad++; $display("FAIL ovr_valid_held: got %b, expected 1", valid);
        end
        n_cmp++;
        if (data !== 8'hA5) begin
            n_bad++; $display("FAIL ovr_data_held: got %02h, expected a5", data);
        end
        n_cmp++;
        if (err_seen !== 1) begin
            n_bad++; $display("FAIL ovr_error: got %0d pulses, expected 1", err_seen);
        end
        ready = 1'b1;
        step(10);
        exp_q = '{8'hA5};
        check_queue("ovr", exp_q);
        n_cmp++;
        if (valid !== 1'b0) begin
            n_bad++; $display("FAIL ovr_valid_after: got %b, expected 0", valid);
        end
    endtask

    task automatic test_framing();
        logic [7:0] exp_q[$];
        clear_mon();
        ready = 1'b1;
        send(8'($urandom), 1'b0);
        step(40 * CPB);
        rx = 1'b1;
        step(2 * CPB);
        n_cmp++;
        if (err_seen !== 1) begin
            n_bad++; $display("FAIL frame_error: got %0d pulses, expected 1", err_seen);
        end
        n_cmp++;
        if (valid_cycles !== 0) begin
            n_bad++; $display("FAIL frame_no_valid: got %0d valid cycles, expected 0",
                              valid_cycles);
        end
        send(8'h65, 1'b1);
        step(20);
        exp_q = '{8'h65};
        check_queue("frame_next", exp_q);
        n_cmp++;
        if (err_seen !== 1) begin
            n_bad++; $display("FAIL frame_next_error: got %0d pulses, expected 1", err_seen);
        end
    endtask

    task automatic test_glitch();
        clear_mon();
        rx = 1'b0;
        step(4);
        rx = 1'b1;
        step(3 * CPB);
        n_cmp++;
        if (valid_cycles !== 0) begin
            n_bad++; $display("FAIL glitch_valid: got %0d valid cycles, expected 0",
                              valid_cycles);
        end
        n_cmp++;
        if (err_seen !== 0) begin
            n_bad++; $display("FAIL glitch_error: got %0d pulses, expected 0", err_seen);
        end
        n_cmp++;
        if (dut.state_q !== IDLE) begin
            n_bad++; $display("FAIL glitch_state: got %0d, expected %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_q[$];
        logic [7:0] b;
        clear_mon();
        ready = 1'b1;
        // Abort 0xFF halfway through bit 4.
        rx = 1'b0;
        step(CPB);
        rx = 1'b1;
        step(4 * CPB + CPB / 2);
        rst = 1'b1;
        step(2);
        n_cmp++;
        if ({valid, error, data} !== 10'd0) begin
            n_bad++; $display("FAIL rstmid_outputs: got v=%b e=%b d=%02h, expected all 0",
                              valid, error, data);
        end
        rst = 1'b0;
        step(CPB);
        send(8'h01, 1'b1);
        step(20);
        exp_q = '{8'h01};
        check_queue("rstmid", exp_q);
        n_cmp++;
        if (valid_cycles !== 1 || err_seen !== 0) begin
            n_bad++; $display("FAIL rstmid_single: got %0d valid / %0d err, expected 1 / 0",
                              valid_cycles, err_seen);
        end
        // Reset released while the line is low: the low level is a fresh start bit.
        clear_mon();
        b  = 8'($urandom);
        rx = 1'b0;
        step(4);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            step(CPB);
        end
        rx = 1'b1;
        step(CPB + 20);
        exp_q = '{b};
        check_queue("rst_low", exp_q);
    endtask

    initial begin
        clear_mon();
        valid_prev = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_framing();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
